// File: rtl/reg_file_bypass_pkg.sv
// Shared types and constants for the decode-stage register file.
package reg_file_bypass_pkg;

    localparam int DATA_WIDTH   = 16;
    localparam int REG_ID_WIDTH = 4;
    localparam int NUM_REGS     = 16;

    typedef logic [REG_ID_WIDTH-1:0] reg_id_t;
    typedef logic [DATA_WIDTH-1:0]   word_t;

    localparam reg_id_t ZERO_REG = 4'd0;

    // 4-to-16 one-hot wordline decode of a register id.
    function automatic logic [NUM_REGS-1:0] dec4to16(input reg_id_t id);
        logic [NUM_REGS-1:0] wl;
        wl = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            wl[i] = (id == reg_id_t'(i));
        end
        return wl;
    endfunction

endpackage

// File: rtl/reg_file_bypass_if.sv
// Decode-stage register file bus: two read ports and one write port.
// There is no valid/ready handshake here. Read ids and write controls are
// level signals sampled every cycle. SrcData1/SrcData2 are combinational
// functions of the current ids, and a write commits on the rising clock edge
// while WriteReg is high.
interface reg_file_bypass_if #(
    parameter int DATA_WIDTH = 16
);
    import reg_file_bypass_pkg::*;

    reg_id_t               SrcReg1;
    reg_id_t               SrcReg2;
    reg_id_t               DstReg;
    logic                  WriteReg;
    logic [DATA_WIDTH-1:0] DstData;
    logic [DATA_WIDTH-1:0] SrcData1;
    logic [DATA_WIDTH-1:0] SrcData2;

    // The decode logic drives the ids and write data.
    modport master (
        output SrcReg1, SrcReg2, DstReg, WriteReg, DstData,
        input  SrcData1, SrcData2
    );

    // The register file returns the read data.
    modport slave (
        input  SrcReg1, SrcReg2, DstReg, WriteReg, DstData,
        output SrcData1, SrcData2
    );

endinterface

// File: rtl/reg_file_bypass_reg_word.sv
// One register word with a synchronous clear and a load enable.
module reg_word #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             WriteEnable,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q
);

    // Clear has priority over load. Otherwise the word holds its value.
    always_ff @(posedge clk) begin
        if (rst) begin
            Q <= '0;
        end else if (WriteEnable) begin
            Q <= D;
        end
    end

endmodule

// File: rtl/reg_file_bypass.sv
// 16 x 16 register file with two combinational read ports, one clocked write
// port, and optional same-cycle write-to-read forwarding. R0 always reads zero.
module reg_file_bypass
    import reg_file_bypass_pkg::*;
#(
    parameter int DATA_WIDTH = reg_file_bypass_pkg::DATA_WIDTH,
    parameter int NUM_REGS   = reg_file_bypass_pkg::NUM_REGS,
    parameter bit BYPASS_EN  = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    reg_file_bypass_if.slave   bus
);

    // The register-id decoders are 4-to-16, so any other register count is invalid.
    generate
        if (NUM_REGS != 16) begin : g_bad_num_regs
            $error("reg_file_bypass: NUM_REGS must be 16");
        end
    endgenerate

    // Bit 0 is masked so the R0 word never loads.
    localparam logic [NUM_REGS-1:0] R0_MASK = ~{{(NUM_REGS-1){1'b0}}, 1'b1};

    logic [NUM_REGS-1:0]   wr_wl;
    logic [NUM_REGS-1:0]   rd_wl1;
    logic [NUM_REGS-1:0]   rd_wl2;
    logic [DATA_WIDTH-1:0] q [NUM_REGS];
    logic [DATA_WIDTH-1:0] rd_data1;
    logic [DATA_WIDTH-1:0] rd_data2;
    logic                  fwd1;
    logic                  fwd2;

    // The write wordline is qualified by WriteReg, and the read wordlines come from separate decoders.
    always_comb begin
        wr_wl  = dec4to16(bus.DstReg) & {NUM_REGS{bus.WriteReg}} & R0_MASK;
        rd_wl1 = dec4to16(bus.SrcReg1);
        rd_wl2 = dec4to16(bus.SrcReg2);
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_regs
            reg_word #(.WIDTH(DATA_WIDTH)) u_word (
                .clk         (clk),
                .rst         (rst),
                .WriteEnable (wr_wl[gi]),
                .D           (bus.DstData),
                .Q           (q[gi])
            );
        end
    endgenerate

    // One-hot AND-OR read mux for each port.
    always_comb begin
        rd_data1 = '0;
        rd_data2 = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            rd_data1 = rd_data1 | ({DATA_WIDTH{rd_wl1[i]}} & q[i]);
            rd_data2 = rd_data2 | ({DATA_WIDTH{rd_wl2[i]}} & q[i]);
        end
    end

    // Forward the write data when the same non-zero register is being written this cycle.
    // The path stays live during reset, even though no write commits then.
    always_comb begin
        fwd1 = BYPASS_EN && bus.WriteReg && (bus.DstReg != ZERO_REG) &&
               (bus.DstReg == bus.SrcReg1);
        fwd2 = BYPASS_EN && bus.WriteReg && (bus.DstReg != ZERO_REG) &&
               (bus.DstReg == bus.SrcReg2);
    end

    // Select the forwarded data or the stored data. R0 never forwards because fwdN excludes it.
    always_comb begin
        bus.SrcData1 = fwd1 ? bus.DstData : rd_data1;
        bus.SrcData2 = fwd2 ? bus.DstData : rd_data2;
    end

endmodule
